// File: rtl/trap_if.sv
// Trap sequencer bus: interrupt sources, CSR enables, exception/mret
// requests and mtvec/mepc come from the pipeline (master). Trap strobe,
// flush, redirect handshake and busy go back to it (slave = sequencer).
//   master: drives requests/CSR state/redirect_ack, observes trap outputs
//   slave : the trap sequencer itself
interface trap_if;
    logic        ext_irq;
    logic        tmr_irq;
    logic        sw_irq;
    logic        csr_rmie;
    logic        csr_meie;
    logic        csr_mtie;
    logic        csr_msie;
    logic        inst_boundary;
    logic        exc_req;
    logic [5:0]  exc_code;
    logic        mret_req;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic [29:0] mepc;
    logic        redirect_ack;

    logic        trap_take;
    logic [6:0]  trap_cause;
    logic        flush;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        mret_done;
    logic        busy;

    modport master (
        output ext_irq, tmr_irq, sw_irq, csr_rmie, csr_meie, csr_mtie, csr_msie,
               inst_boundary, exc_req, exc_code, mret_req, mtvec_base, mtvec_mode,
               mepc, redirect_ack,
        input  trap_take, trap_cause, flush, redirect_valid, redirect_pc,
               mret_done, busy
    );

    modport slave (
        input  ext_irq, tmr_irq, sw_irq, csr_rmie, csr_meie, csr_mtie, csr_msie,
               inst_boundary, exc_req, exc_code, mret_req, mtvec_base, mtvec_mode,
               mepc, redirect_ack,
        output trap_take, trap_cause, flush, redirect_valid, redirect_pc,
               mret_done, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap / mret sequencer.
// Arbitrates exception > mret > interrupt in IDLE, strobes trap_take for the
// CSR file, kills the pipeline for FLUSH_CYC cycles, then holds a redirect
// to the fetch unit until it is acknowledged.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tif        : trap_if.slave bundle (requests in, trap/flush/redirect out)
module trap_sequencer #(
    parameter int unsigned FLUSH_CYC = 2   // 1..15
) (
    input logic   clk,
    input logic   rst_n,
    trap_if.slave tif
);

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, REDIRECT} state_e;

    // Counter runs FLUSH_CYC-1 .. 0, so flush is high FLUSH_CYC cycles.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYC - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [6:0]  cause_q;
    logic        mret_q;
    logic [29:0] pc_q;
    logic        trap_take_q;
    logic        flush_q;
    logic        redirect_valid_q;
    logic        busy_q;

    logic        ext_en, sw_en, tmr_en, irq_go;
    logic [6:0]  irq_cause;
    logic [29:0] trap_target;

    assign ext_en = tif.ext_irq & tif.csr_meie;
    assign sw_en  = tif.sw_irq  & tif.csr_msie;
    assign tmr_en = tif.tmr_irq & tif.csr_mtie;
    assign irq_go = tif.csr_rmie & tif.inst_boundary & (ext_en | sw_en | tmr_en);

    assign irq_cause = ext_en ? 7'h4B : (sw_en ? 7'h43 : 7'h47);

    // Only interrupts are vectored; the add wraps modulo 2^30.
    assign trap_target = (tif.mtvec_mode && cause_q[6])
                       ? tif.mtvec_base + {24'd0, cause_q[5:0]}
                       : tif.mtvec_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cause_q          <= '0;
            mret_q           <= 1'b0;
            pc_q             <= '0;
            trap_take_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            trap_take_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tif.exc_req) begin
                        cause_q     <= {1'b0, tif.exc_code};
                        mret_q      <= 1'b0;
                        trap_take_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= CAPTURE;
                    end else if (tif.mret_req) begin
                        cause_q <= '0;
                        mret_q  <= 1'b1;
                        pc_q    <= tif.mepc;
                        flush_q <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= FLUSH;
                    end else if (irq_go) begin
                        cause_q     <= irq_cause;
                        mret_q      <= 1'b0;
                        trap_take_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pc_q    <= trap_target;
                    flush_q <= 1'b1;
                    cnt_q   <= CNT_LOAD;
                    state_q <= FLUSH;
                end
                FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        state_q          <= REDIRECT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (tif.redirect_ack) begin
                        redirect_valid_q <= 1'b0;
                        busy_q           <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tif.trap_take      = trap_take_q;
    assign tif.trap_cause     = trap_take_q ? cause_q : 7'd0;
    assign tif.flush          = flush_q;
    assign tif.redirect_valid = redirect_valid_q;
    assign tif.redirect_pc    = redirect_valid_q ? pc_q : 30'd0;
    // Pulses in the same cycle the fetch unit acknowledges an mret redirect.
    assign tif.mret_done      = redirect_valid_q & mret_q & tif.redirect_ack;
    assign tif.busy           = busy_q;

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter FLUSH_CYC, default 2, pipeline flush length in cycles; legal range 1..15.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ext_irq, tmr_irq, sw_irq  in  1 each  level-sensitive interrupt sources.
REQ-005 csr_rmie, csr_meie, csr_mtie, csr_msie  in  1 each  global and per-source machine interrupt enables.
REQ-006 inst_boundary  in  1  high when no instruction is partially executed; interrupts are accepted only then.
REQ-007 exc_req  in  1  synchronous exception (illegal, ecall, ebreak) from EX.
REQ-008 exc_code  in  6  exception cause code, valid with exc_req.
REQ-009 mret_req  in  1  mret executing in EX.
REQ-010 mtvec_base  in  30  trap vector base [31:2].
REQ-011 mtvec_mode  in  1  0 = direct, 1 = vectored.
REQ-012 mepc  in  30  return PC [31:2].
REQ-013 redirect_ack  in  1  fetch unit accepted the redirect.
REQ-014 trap_take  out  1  one-cycle strobe; CSR file latches mepc/mcause/mtval/mstatus.
REQ-015 trap_cause  out  7  {interrupt bit, code[5:0]}, valid with trap_take.
REQ-016 flush  out  1  pipeline kill.
REQ-017 redirect_valid  out  1  redirect_pc is valid.
REQ-018 redirect_pc  out  30  new fetch PC [31:2].
REQ-019 mret_done  out  1  one-cycle strobe when an mret redirect is accepted.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, CAPTURE, FLUSH, REDIRECT.
REQ-022 Effective interrupts: ext = ext_irq&csr_meie; sw = sw_irq&csr_msie; tmr = tmr_irq&csr_mtie.
REQ-023 irq_go = csr_rmie & inst_boundary & (ext|sw|tmr).
REQ-024 IDLE arbitration, priority high to low: exc_req > mret_req > irq_go.
  - Winner is registered into cause/kind registers.
  - Next state: CAPTURE for exception or interrupt; FLUSH for mret.
REQ-025 Interrupt priority: ext (code 11) > sw (code 3) > tmr (code 7); interrupt bit = 1.
REQ-026 Exception cause = {0, exc_code}.
REQ-027 CAPTURE lasts exactly 1 cycle.
  - trap_take = 1 and trap_cause = registered cause.
  - Next state: FLUSH.
REQ-028 FLUSH: flush = 1 for exactly FLUSH_CYC cycles, counted by a 4-bit down-counter loaded on FLUSH entry; next state REDIRECT.
REQ-029 REDIRECT: redirect_valid = 1 and redirect_pc held stable until redirect_ack is sampled high; then return to IDLE.
REQ-030 Trap target PC:
  - Vectored mode with interrupt: mtvec_base + code, 30-bit add, wrap-around modulo 2^30.
  - Otherwise: mtvec_base.
  - Target is computed and registered in CAPTURE.
REQ-031 mret target = mepc, registered on IDLE exit; mret_done = 1 in the cycle redirect_ack is accepted.
REQ-032 While busy: exc_req and mret_req are ignored, since the pipeline is being flushed; interrupt levels are not latched and are re-evaluated in IDLE.
REQ-033 redirect_ack outside REDIRECT is ignored.
REQ-034 Back-to-back: IDLE is occupied for at least 1 cycle between sequences.
REQ-035 Minimum trap latency: request in IDLE -> trap_take next cycle -> redirect_valid at 2+FLUSH_CYC cycles after the request.

Reset
REQ-036 Asynchronous reset while rst_n = 0 forces:
  - state = IDLE, counter = 0, cause/target registers = 0.
  - All outputs (trap_take, trap_cause, flush, redirect_valid, redirect_pc, mret_done, busy) = 0.
REQ-037 Reset asserted mid-sequence aborts the sequence immediately; no strobe is emitted after rst_n deasserts until a new request arrives.

Verification
REQ-038 exc_req with exc_code = 2, mtvec_base = 0x100, mode = 0, FLUSH_CYC = 2.
  - trap_take at cycle +1 with trap_cause = 0x02.
  - flush at cycles +2..+3.
  - redirect_pc = 0x100 at cycle +4; ack -> busy = 0.
REQ-039 ext_irq, tmr_irq, sw_irq all high with all enables and inst_boundary = 1, mode = 1, base = 0x100.
  - trap_cause = 0x4B, redirect_pc = 0x10B.
  - With ext_irq low instead: trap_cause = 0x43, redirect_pc = 0x103.
REQ-040 exc_req, mret_req and ext_irq asserted in the same IDLE cycle.
  - Exception is taken.
  - mret_req asserted during FLUSH is ignored; mret_done is never asserted.
REQ-041 mret_req with mepc = 0x2000.
  - No trap_take.
  - flush for FLUSH_CYC cycles, then redirect_pc = 0x2000.
  - redirect_ack held low for 5 cycles: outputs stay stable; mret_done pulses with the ack.
REQ-042 Interrupt gating, then reset.
  - csr_rmie = 0 or inst_boundary = 0 with tmr_irq high: no trap.
  - Reset during FLUSH: all outputs 0 immediately and state = IDLE.
REQ-043 Vectored wrap: base = 0x3FFFFFFF with ext interrupt gives redirect_pc = 0x0000000A.
